// File: rtl/trivium_stream_core.sv
// -----------------------------------------------------------------------------
// trivium_stream_core
//
// Trivium stream-cipher engine producing W keystream bits per clock. The core
// takes an 80-bit key and 80-bit IV through a valid/ready handshake, runs the
// warm-up rounds, then XORs a framed data stream with keystream under
// valid/ready flow control. Encryption and decryption are the same operation.
//
// Optional build macro: TRIVIUM_ERR_CNT_EN adds o_err_count, a saturating
// count of o_err pulses that only rst clears.
//
// Parameters
//   W            keystream/data bits per cycle (1,2,4,8,16,32,64)
//   INIT_ROUNDS  warm-up rounds, a multiple of W
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   i_abort      synchronous abort back to IDLE, wipes the cipher state
//   i_key_valid  key/IV offer           o_key_ready  core accepts key/IV
//   i_key        key, i_key[i] -> s(i+1)
//   i_iv         IV,  i_iv[i]  -> s(94+i)
//   i_in_valid   input word valid       o_in_ready   input word accepted
//   i_in_data    plaintext/ciphertext   i_in_last    final word of message
//   o_out_valid  output word valid      i_out_ready  downstream accepts
//   o_out_data   i_in_data ^ keystream  o_out_last   registered i_in_last
//   o_busy       high in LOAD, INIT, RUN and LAST
//   o_err        protocol error: input offered before the core can take it
//   o_err_count  (TRIVIUM_ERR_CNT_EN only) saturating error count
//
// State    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for key/IV, cipher state zero
// S_LOAD   | key/IV captured, arming the warm-up counter
// S_INIT   | warm-up rounds, keystream discarded
// S_RUN    | streaming data words
// S_LAST   | final word held until downstream takes it
// -----------------------------------------------------------------------------
module trivium_stream_core #(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_abort,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [79:0]  i_key,
    input  logic [79:0]  i_iv,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    input  logic         i_in_last,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data,
    output logic         o_out_last,
    output logic         o_busy,
    output logic         o_err
`ifdef TRIVIUM_ERR_CNT_EN
    ,
    output logic [15:0]  o_err_count
`endif
);

    localparam int N_INIT = INIT_ROUNDS / W;
    localparam int CW     = (N_INIT > 1) ? $clog2(N_INIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_INIT = 3'd2,
        S_RUN  = 3'd3,
        S_LAST = 3'd4
    } state_t;

    state_t         r_state;
    logic [287:0]   r_s;        // r_s[k-1] holds Trivium bit s(k)
    logic [CW-1:0]  r_cnt;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_out_last;

    logic [287:0]   w_s_adv;
    logic [W-1:0]   w_ks;
    logic           w_in_fire;
    logic           w_err;
    logic [287:0]   w_s_load;

    // W rounds unrolled; keystream bit j comes from the j-th round.
    always_comb begin
        logic [287:0] s;
        logic         t1;
        logic         t2;
        logic         t3;
        s    = r_s;
        w_ks = '0;
        t1   = 1'b0;
        t2   = 1'b0;
        t3   = 1'b0;
        for (int j = 0; j < W; j++) begin
            t1      = s[65] ^ s[92];
            t2      = s[161] ^ s[176];
            t3      = s[242] ^ s[287];
            w_ks[j] = t1 ^ t2 ^ t3;
            t1      = t1 ^ (s[90] & s[91]) ^ s[170];
            t2      = t2 ^ (s[174] & s[175]) ^ s[263];
            t3      = t3 ^ (s[285] & s[286]) ^ s[68];
            s       = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        w_s_adv = s;
    end

    assign w_s_load = {3'b111, 112'd0, i_iv, 13'd0, i_key};

    assign o_key_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    // Abort masks the handshake so upstream never sees a word "taken" that
    // is then thrown away.
    assign o_in_ready  = (r_state == S_RUN) && (!r_out_valid || i_out_ready) && !i_abort;
    assign w_in_fire   = o_in_ready && i_in_valid;
    assign w_err       = !i_abort && i_in_valid &&
                         ((r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_INIT));
    assign o_err       = w_err;

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_s         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (i_abort) begin
            r_state     <= S_IDLE;
            r_s         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_key_valid) begin
                        r_s     <= w_s_load;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= CW'(N_INIT - 1);
                    r_state <= S_INIT;
                end
                S_INIT: begin
                    r_s <= w_s_adv;
                    if (r_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_in_fire) begin
                        r_out_data  <= i_in_data ^ w_ks;
                        r_out_last  <= i_in_last;
                        r_out_valid <= 1'b1;
                        r_s         <= w_s_adv;
                        if (i_in_last) begin
                            r_state <= S_LAST;
                        end
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_LAST: begin
                    if (r_out_valid && i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_s         <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TRIVIUM_ERR_CNT_EN
    logic [15:0] r_err_count;

    // Survives abort so software can read the history after recovery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_trivium_stream_core.sv
// -----------------------------------------------------------------------------
// tb_trivium_stream_core
//
// Bench for trivium_stream_core. A W=8 instance carries the directed
// sequence (reset, warm-up timing, keystream, round trip with random
// backpressure, protocol errors, abort); W=1 and W=64 instances stream the
// same key/IV to show the keystream does not depend on W. Expected values
// come from a bit-serial Trivium model written directly from the round
// equations.
// -----------------------------------------------------------------------------
module tb_trivium_stream_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_errs = 0;

    // W=8 instance
    logic        abort8 = 0, kv8 = 0, in_valid8 = 0, in_last8 = 0, out_ready8 = 1;
    logic [79:0] key8 = '0, iv8 = '0;
    logic [7:0]  in_data8 = '0;
    logic        kr8, in_ready8, out_valid8, out_last8, busy8, err8;
    logic [7:0]  out_data8;
`ifdef TRIVIUM_ERR_CNT_EN
    logic [15:0] errc8, errc1, errc64;
`endif

    trivium_stream_core #(.W(8), .INIT_ROUNDS(1152)) u8 (
        .clk(clk), .rst(rst), .i_abort(abort8),
        .i_key_valid(kv8), .o_key_ready(kr8), .i_key(key8), .i_iv(iv8),
        .i_in_valid(in_valid8), .o_in_ready(in_ready8), .i_in_data(in_data8), .i_in_last(in_last8),
        .o_out_valid(out_valid8), .i_out_ready(out_ready8), .o_out_data(out_data8), .o_out_last(out_last8),
        .o_busy(busy8), .o_err(err8)
`ifdef TRIVIUM_ERR_CNT_EN
        , .o_err_count(errc8)
`endif
    );

    // W=1 and W=64 instances sharing stimulus
    logic        wabort = 0, wkv = 0, win_valid = 0;
    logic [79:0] wkey = '0, wiv = '0;
    logic        kr1, in_ready1, out_valid1, out_last1, busy1, err1;
    logic [0:0]  out_data1;
    logic        kr64, in_ready64, out_valid64, out_last64, busy64, err64;
    logic [63:0] out_data64;

    trivium_stream_core #(.W(1), .INIT_ROUNDS(1152)) u1 (
        .clk(clk), .rst(rst), .i_abort(wabort),
        .i_key_valid(wkv), .o_key_ready(kr1), .i_key(wkey), .i_iv(wiv),
        .i_in_valid(win_valid), .o_in_ready(in_ready1), .i_in_data(1'b0), .i_in_last(1'b0),
        .o_out_valid(out_valid1), .i_out_ready(1'b1), .o_out_data(out_data1), .o_out_last(out_last1),
        .o_busy(busy1), .o_err(err1)
`ifdef TRIVIUM_ERR_CNT_EN
        , .o_err_count(errc1)
`endif
    );

    trivium_stream_core #(.W(64), .INIT_ROUNDS(1152)) u64 (
        .clk(clk), .rst(rst), .i_abort(wabort),
        .i_key_valid(wkv), .o_key_ready(kr64), .i_key(wkey), .i_iv(wiv),
        .i_in_valid(win_valid), .o_in_ready(in_ready64), .i_in_data(64'd0), .i_in_last(1'b0),
        .o_out_valid(out_valid64), .i_out_ready(1'b1), .o_out_data(out_data64), .o_out_last(out_last64),
        .o_busy(busy64), .o_err(err64)
`ifdef TRIVIUM_ERR_CNT_EN
        , .o_err_count(errc64)
`endif
    );

    // Output collectors (sample the pre-edge handshake)
    bit         q1[$];
    bit         q64[$];
    logic [7:0] mon_d[$];
    bit         mon_l[$];

    always @(posedge clk) begin
        if (out_valid1 && q1.size() < 512) q1.push_back(out_data1[0]);
        if (out_valid64 && q64.size() < 512)
            for (int k = 0; k < 64; k++) q64.push_back(out_data64[k]);
        if (out_valid8 && out_ready8) begin
            mon_d.push_back(out_data8);
            mon_l.push_back(out_last8);
        end
    end

    // Bit-serial reference model: keystream bits after the 1152 warm-up rounds
    bit ks_m[0:2047];

    task automatic ref_ks(input logic [79:0] k, input logic [79:0] v, input int nbits);
        bit s[1:288];
        bit t1, t2, t3;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            s[i + 1]  = k[i];
            s[94 + i] = v[i];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + nbits; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            if (r >= 1152) ks_m[r - 1152] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 93; i > 1; i--)   s[i] = s[i - 1];
            s[1] = t3;
            for (int i = 177; i > 94; i--) s[i] = s[i - 1];
            s[94] = t1;
            for (int i = 288; i > 178; i--) s[i] = s[i - 1];
            s[178] = t2;
        end
    endtask

    function automatic logic [63:0] ks_word(input int w, input int i);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r[b] = ks_m[w * i + b];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key_hs(input logic [79:0] k, input logic [79:0] v);
        key8 = k; iv8 = v; kv8 = 1'b1;
        @(posedge clk); #1;
        kv8 = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready8 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(tag, in_ready8, 1'b1);
    endtask

    logic [7:0]  msg_in[16];
    logic [79:0] rk, rv;

    // Send the 16-word message in msg_in under random valid/ready; the
    // monitor queues collect what comes out.
    task automatic run_msg(input string tag);
        int i, cyc;
        key_hs(rk, rv);
        out_ready8 = 1'b1;
        wait_run({tag, "_init"});
        mon_d.delete();
        mon_l.delete();
        i = 0;
        cyc = 0;
        while ((i < 16 || mon_d.size() < 16 || !kr8) && cyc < 2000) begin
            out_ready8 = ($urandom_range(0, 3) != 0);
            in_valid8  = (i < 16) && ($urandom_range(0, 3) != 0);
            in_data8   = (i < 16) ? msg_in[i] : 8'd0;
            in_last8   = (i == 15);
            @(negedge clk);
            if (in_valid8 && in_ready8) i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid8  = 1'b0;
        in_last8   = 1'b0;
        out_ready8 = 1'b1;
        chk({tag, "_done"}, (cyc < 2000), 1'b1);
        chk({tag, "_idle_key_ready"}, kr8, 1'b1);
        chk({tag, "_idle_busy"}, busy8, 1'b0);
    endtask

    logic [7:0]  pt[16];
    logic [7:0]  ct[16];
    logic [95:0] rnd;
    logic [63:0] kw, g1, g64;
    int          n;

    initial begin
        // ---------------- reset ----------------
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_ready", kr8, 1'b1);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_out_valid", out_valid8, 1'b0);
        chk("rst_out_data", out_data8, 8'd0);
        chk("rst_out_last", out_last8, 1'b0);
        chk("rst_err", err8, 1'b0);
`ifdef TRIVIUM_ERR_CNT_EN
        chk("rst_err_count", errc8, 16'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- input offered in IDLE ----------------
        in_valid8 = 1'b1;
        #2;
        chk("idle_err", err8, 1'b1);
        chk("idle_in_ready", in_ready8, 1'b0);
        exp_errs++;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        #2;
        chk("idle_err_clear", err8, 1'b0);
        @(posedge clk); #1;

        // ---------------- warm-up timing ----------------
        key_hs(80'h0, 80'h0);
        chk("load_busy", busy8, 1'b1);
        chk("load_key_ready", kr8, 1'b0);
        n = 0;
        while (!in_ready8 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("warmup_cycles", n, 145);

        // ---------------- keystream, key=0 iv=0 ----------------
        ref_ks(80'h0, 80'h0, 256);
        for (int i = 0; i < 32; i++) begin
            in_valid8 = 1'b1;
            in_data8  = 8'd0;
            in_last8  = (i == 31);
            @(posedge clk); #1;
            kw = ks_word(8, i);
            chk($sformatf("ks0_valid_%0d", i), out_valid8, 1'b1);
            chk($sformatf("ks0_data_%0d", i), out_data8, kw[7:0]);
            chk($sformatf("ks0_last_%0d", i), out_last8, (i == 31));
        end
        in_valid8 = 1'b0;
        in_last8  = 1'b0;
        @(posedge clk); #1;
        chk("ks0_end_key_ready", kr8, 1'b1);
        chk("ks0_end_out_valid", out_valid8, 1'b0);
        chk("ks0_end_out_last", out_last8, 1'b0);
        chk("ks0_end_busy", busy8, 1'b0);

        // ---------------- width independence W=1 vs W=64 ----------------
        ref_ks(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC, 512);
        wkey = 80'h0123456789ABCDEF0123;
        wiv  = 80'hFEDCBA9876543210FEDC;
        wkv  = 1'b1;
        @(posedge clk); #1;
        wkv = 1'b0;
        win_valid = 1'b1;
        n = 0;
        while ((q1.size() < 512 || q64.size() < 512) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("width_collect_done", (n < 3000), 1'b1);
        win_valid = 1'b0;
        wabort = 1'b1;
        @(posedge clk); #1;
        wabort = 1'b0;
        chk("width_abort_kr1", kr1, 1'b1);
        chk("width_abort_kr64", kr64, 1'b1);
        for (int c = 0; c < 8; c++) begin
            kw = '0; g1 = '0; g64 = '0;
            for (int b = 0; b < 64; b++) begin
                kw[b]  = ks_m[64 * c + b];
                if (q1.size() > 64 * c + b)  g1[b]  = q1[64 * c + b];
                if (q64.size() > 64 * c + b) g64[b] = q64[64 * c + b];
            end
            chk($sformatf("w1_chunk_%0d", c), g1, kw);
            chk($sformatf("w64_chunk_%0d", c), g64, kw);
        end

        // ---------------- round trip with backpressure ----------------
        rnd = {$urandom, $urandom, $urandom};
        rk  = rnd[79:0];
        rnd = {$urandom, $urandom, $urandom};
        rv  = rnd[79:0];
        ref_ks(rk, rv, 128);
        for (int i = 0; i < 16; i++) begin
            pt[i]     = 8'($urandom_range(0, 255));
            msg_in[i] = pt[i];
        end
        run_msg("enc");
        chk("enc_count", mon_d.size(), 16);
        for (int j = 0; j < 16; j++) begin
            kw = ks_word(8, j);
            ct[j] = (j < mon_d.size()) ? mon_d[j] : 8'd0;
            chk($sformatf("enc_data_%0d", j), ct[j], pt[j] ^ kw[7:0]);
            chk($sformatf("enc_last_%0d", j), (j < mon_l.size()) ? mon_l[j] : 1'b0, (j == 15));
        end
        for (int i = 0; i < 16; i++) msg_in[i] = ct[i];
        run_msg("dec");
        chk("dec_count", mon_d.size(), 16);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("dec_data_%0d", j), (j < mon_d.size()) ? mon_d[j] : 8'd0, pt[j]);
            chk($sformatf("dec_last_%0d", j), (j < mon_l.size()) ? mon_l[j] : 1'b0, (j == 15));
        end

        // ---------------- protocol errors during INIT ----------------
        key_hs(80'h0, 80'h0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            #2;
            chk($sformatf("init_err_%0d", i), err8, 1'b1);
            chk($sformatf("init_in_ready_%0d", i), in_ready8, 1'b0);
            exp_errs++;
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        kv8 = 1'b1;
        #2;
        chk("init_keyvalid_no_err", err8, 1'b0);
        chk("init_key_ready", kr8, 1'b0);
        @(posedge clk); #1;
        kv8 = 1'b0;
        chk("init_still_busy", busy8, 1'b1);
        abort8 = 1'b1;
        in_valid8 = 1'b1;
        #2;
        chk("abort_masks_err", err8, 1'b0);
        @(posedge clk); #1;
        abort8 = 1'b0;
        in_valid8 = 1'b0;
        chk("init_abort_key_ready", kr8, 1'b1);
        chk("init_abort_busy", busy8, 1'b0);

        // ---------------- abort mid-RUN with a word in flight ----------------
        out_ready8 = 1'b0;
        key_hs(80'h0, 80'h0);
        wait_run("run2_init");
        in_valid8 = 1'b1;
        in_data8  = 8'hA5;
        in_last8  = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("stall_out_valid", out_valid8, 1'b1);
        chk("stall_in_ready", in_ready8, 1'b0);
        abort8 = 1'b1;
        @(posedge clk); #1;
        abort8 = 1'b0;
        chk("run_abort_out_valid", out_valid8, 1'b0);
        chk("run_abort_out_last", out_last8, 1'b0);
        chk("run_abort_key_ready", kr8, 1'b1);
        chk("run_abort_busy", busy8, 1'b0);
        out_ready8 = 1'b1;

`ifdef TRIVIUM_ERR_CNT_EN
        chk("err_count_after_abort", errc8, 16'(exp_errs));
        rst = 1'b0;
        #2;
        chk("err_count_rst", errc8, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trivium_stream_core.md
Name: trivium_stream_core

Overview:
- Parametrised Trivium stream-cipher engine, W keystream bits per clock.
- Loads an 80-bit key and 80-bit IV, runs the warm-up rounds, then XORs a framed data stream with keystream under valid/ready flow control.
- Successor to the single-bit Trivium datapath: adds key/IV handshake, explicit init phase, end-of-data framing, protocol-error flag and abort.
- Sits between the key-management block and the data path; the same core encrypts and decrypts.

Parameters:
- W, 8, keystream/data bits per cycle; legal values 1,2,4,8,16,32,64.
- INIT_ROUNDS, 1152, warm-up rounds; must be a multiple of W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- abort  in  1  synchronous abort; returns the core to IDLE.
- key_valid  in  1  key/IV offer.
- key_ready  out  1  core accepts key/IV.
- key  in  80  key; key[i] loads s(i+1).
- iv  in  80  IV; iv[i] loads s(94+i).
- in_valid  in  1  input data valid.
- in_ready  out  1  input data accepted.
- in_data  in  W  plaintext or ciphertext.
- in_last  in  1  marks the final word of a message.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  W  in_data XOR keystream.
- out_last  out  1  registered copy of in_last.
- busy  out  1  high in LOAD, INIT, RUN and LAST.
- err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset: state=IDLE, s1..s288=0, round counter=0; out_valid=0, out_data=0, out_last=0, err=0, busy=0, key_ready=1.
- State: 288-bit register s1..s288.
- Round function:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - Shift: s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
- Each advance applies W rounds combinationally. z of the j-th round (j=0 first) forms keystream bit ks[j].
- FSM:
  - IDLE: key_ready=1. On key_valid, load s1..s80=key, s81..s93=0, s94..s173=iv, s174..s285=0, s286..s288=1, then go to INIT.
  - INIT: advance W rounds per cycle with output discarded; exactly INIT_ROUNDS/W cycles (144 for W=8); then go to RUN.
  - RUN: in_ready = !out_valid || out_ready. On in_valid&&in_ready, register out_data=in_data^ks, out_last=in_last, out_valid=1, and advance state by W rounds.
    - If in_last was accepted, go to LAST.
    - If out_ready with no new input, clear out_valid.
  - LAST: in_ready=0. When out_valid&&out_ready, clear out_valid and out_last, zero s1..s288, and go to IDLE.
- Latency: one cycle from input handshake to out_valid.
- Throughput: W bits per cycle with out_ready held high.
- Output hold: out_data and out_last stay stable while out_valid&&!out_ready.
- key_ready is 0 outside IDLE; key_valid outside IDLE is ignored and raises no error.
- Protocol error: in_valid in IDLE, LOAD or INIT → err=1 for that cycle; data is not consumed (in_ready=0). If the condition persists, err repeats every cycle.
- abort:
  - Has priority over all handshakes.
  - Next state is IDLE; clears out_valid, out_last and s1..s288; no err.
  - The output word in flight is dropped.
- Simultaneous out_ready and new input accept in RUN: the new word replaces the old one, and out_valid stays 1.
- Keystream continuity: the bit sequence is independent of W. The same key/IV with W=1 or W=64 yields the identical keystream stream in bit order.

Optional Feature:
- Macro TRIVIUM_ERR_CNT_EN.
- Defined: adds output err_count[15:0], a saturating count (stops at 16'hFFFF) of err pulses. Cleared by rst only, not by abort.
- Undefined: port absent, no counter logic.

Test Plan:
- Warm-up timing: key=0, iv=0, W=8, key_valid pulse → busy=1 next cycle; in_ready first rises exactly 145 cycles after the key handshake (1 load + 144 init).
- Keystream: key=80'h0, iv=80'h0, stream 32 words in_data=0 → out_data equals a bit-serial golden model's keystream bits 0..255, packed LSB-first.
- Width independence: same key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC, 512 zero bits at W=1 and W=64 → identical bit streams.
- Round trip and backpressure: encrypt 16 random words with random out_ready toggling, re-key with the same key/IV, decrypt → plaintext recovered; out_last set only on word 16; core returns to IDLE with key_ready=1.
- Protocol errors: in_valid=1 during INIT → err=1 every such cycle, no data consumed; abort mid-RUN with out_valid=1 → out_valid=0 next cycle, state IDLE.
- Feature build: with TRIVIUM_ERR_CNT_EN defined, 3 error cycles → err_count=3; abort leaves it at 3; rst clears it to 0.
